param_scheduler: RTL and testbench

- Responder side of the state_control handshake.
- Watches the controller's 3-bit state, holds the per-read parameter buffer, and finds the next unfinished parameter entry in GET_PARAM, reporting it with is_find.
- Commits updated parameters in WRITE_BACK and raises is_start / is_finish for the controller.
- Sits between the host load port, state_control and the GET_DATA/EX/WRITE_BACK execution modules.

---
 rtl/param_scheduler.sv | 108 ++++++++++
 tb/tb_param_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/param_scheduler.sv
// Parameter scheduler: responder side of state_control; optional stats via PARAM_SCHED_STATS_EN.
// Latency: is_start/is_find/is_finish registered; is_find 1..DEPTH cycles after entering GET_PARAM.
// Backpressure: none; the controller paces it via state, is_find holds until GET_PARAM is left.
module param_scheduler #(
  parameter int DEPTH   = 8,
  parameter int PARAM_W = 32,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_addr,
  input  logic [PARAM_W-1:0] load_data,
  input  logic               start_req,
  input  logic               wb_valid,
  input  logic [PARAM_W-1:0] wb_param,
  input  logic               wb_done,
  output logic               is_start,
  output logic               is_find,
  output logic               is_finish,
  output logic [IDX_W-1:0]   cur_idx,
  output logic [PARAM_W-1:0] cur_param
`ifdef PARAM_SCHED_STATS_EN
  ,
  output logic [15:0]        iter_count,
  output logic [15:0]        scan_cycles
`endif
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GET_PARAM  = 3'd1;
  localparam logic [2:0] ST_WRITE_BACK = 3'd6;

  logic [PARAM_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   pending;
  logic [DEPTH-1:0]   pending_nxt;
  logic [IDX_W-1:0]   scan_ptr;
  logic               started;
  logic               load_fire;
  logic               wb_fire;
  logic               scan_en;

  assign load_fire = (state == ST_IDLE) && load_en;
  assign wb_fire   = (state == ST_WRITE_BACK) && wb_valid;
  assign scan_en   = (state == ST_GET_PARAM) && !is_find;

  // Start decision must see an entry loaded in the same cycle.
  always_comb begin
    pending_nxt = pending;
    if (load_fire) pending_nxt[load_addr] = 1'b1;
    if (wb_fire)   pending_nxt[cur_idx]   = ~wb_done;
  end

  always_ff @(posedge clk) begin
    if (load_fire)    mem[load_addr] <= load_data;
    else if (wb_fire) mem[cur_idx]   <= wb_param;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      scan_ptr  <= '0;
      started   <= 1'b0;
      is_start  <= 1'b0;
      is_find   <= 1'b0;
      is_finish <= 1'b0;
      cur_idx   <= '0;
      cur_param <= '0;
    end else begin
      pending <= pending_nxt;

      if ((state == ST_IDLE) && start_req && !is_start && (pending_nxt != '0)) begin
        is_start <= 1'b1;
        started  <= 1'b1;
      end else begin
        is_start <= 1'b0;
      end

      // Pointer advances past a hit so the next search starts after it (round-robin).
      if (scan_en) begin
        scan_ptr <= scan_ptr + IDX_W'(1);
        if (pending[scan_ptr]) begin
          cur_idx   <= scan_ptr;
          cur_param <= mem[scan_ptr];
          is_find   <= 1'b1;
        end
      end else if (state != ST_GET_PARAM) begin
        is_find <= 1'b0;
      end

      if (started && (pending == '0)) is_finish <= 1'b1;
    end
  end

`ifdef PARAM_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_count  <= '0;
      scan_cycles <= '0;
    end else begin
      if (wb_fire && (iter_count != 16'hFFFF))  iter_count  <= iter_count + 16'd1;
      if (scan_en && (scan_cycles != 16'hFFFF)) scan_cycles <= scan_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_param_scheduler.sv
// Self-checking bench for param_scheduler: scoreboard of expected finds (idx, value, scan latency).
module tb_param_scheduler;
  localparam int DEPTH   = 8;
  localparam int PARAM_W = 32;
  localparam int IDX_W   = 3;

  logic               clk;
  logic               rst;
  logic [2:0]         state;
  logic               load_en;
  logic [IDX_W-1:0]   load_addr;
  logic [PARAM_W-1:0] load_data;
  logic               start_req;
  logic               wb_valid;
  logic [PARAM_W-1:0] wb_param;
  logic               wb_done;
  logic               is_start;
  logic               is_find;
  logic               is_finish;
  logic [IDX_W-1:0]   cur_idx;
  logic [PARAM_W-1:0] cur_param;
`ifdef PARAM_SCHED_STATS_EN
  logic [15:0]        iter_count;
  logic [15:0]        scan_cycles;
`endif

  param_scheduler #(.DEPTH(DEPTH), .PARAM_W(PARAM_W)) dut (
    .clk(clk), .rst(rst), .state(state),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start_req(start_req), .wb_valid(wb_valid), .wb_param(wb_param), .wb_done(wb_done),
    .is_start(is_start), .is_find(is_find), .is_finish(is_finish),
    .cur_idx(cur_idx), .cur_param(cur_param)
`ifdef PARAM_SCHED_STATS_EN
    , .iter_count(iter_count), .scan_cycles(scan_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]   idx;
    logic [PARAM_W-1:0] param;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_find(input logic [IDX_W-1:0] idx, input logic [PARAM_W-1:0] p, input int lat);
    exp_t e;
    e.idx = idx; e.param = p; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [PARAM_W-1:0] d);
    state = 3'd0; load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic start_pulse();
    state = 3'd0; start_req = 1'b1;
    step();
    check_eq("start_pulse", {31'd0, is_start}, 32'd1);
    step();
    check_eq("start_no_extend", {31'd0, is_start}, 32'd0);
    start_req = 1'b0;
  endtask

  task automatic find();
    exp_t e;
    int   lat;
    bit   hit;
    state = 3'd1; lat = 0; hit = 1'b0;
    check_eq("find_pre", {31'd0, is_find}, 32'd0);
    for (int i = 0; i < DEPTH + 2 && !hit; i++) begin
      step();
      lat++;
      if (is_find) hit = 1'b1;
    end
    e = sb.pop_front();
    check_eq("find_hit", {31'd0, hit}, 32'd1);
    check_eq("find_lat", lat, e.lat);
    check_eq("find_idx", {29'd0, cur_idx}, {29'd0, e.idx});
    check_eq("find_param", cur_param, e.param);
    step();
    check_eq("find_hold", {31'd0, is_find}, 32'd1);
  endtask

  task automatic writeback(input logic v, input logic done, input logic [PARAM_W-1:0] p);
    state = 3'd6; wb_valid = v; wb_done = done; wb_param = p;
    step();
    wb_valid = 1'b0; wb_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; state = 3'd0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start_req = 1'b0; wb_valid = 1'b0; wb_param = '0; wb_done = 1'b0;
    repeat (2) step();
    check_eq("rst_is_start", {31'd0, is_start}, 32'd0);
    check_eq("rst_is_find", {31'd0, is_find}, 32'd0);
    check_eq("rst_is_finish", {31'd0, is_finish}, 32'd0);
    check_eq("rst_cur_idx", {29'd0, cur_idx}, 32'd0);
    check_eq("rst_cur_param", cur_param, 32'd0);
    rst = 1'b0;
    step();

    // Start with nothing loaded
    start_req = 1'b1;
    step();
    check_eq("empty_start", {31'd0, is_start}, 32'd0);
    start_req = 1'b0;
    step();
    check_eq("empty_finish", {31'd0, is_finish}, 32'd0);

    load(3'd0, 32'h11);
    load(3'd3, 32'h33);
    start_pulse();

    push_find(3'd0, 32'h11, 1);
    find();
    writeback(1'b1, 1'b0, 32'h12);
    push_find(3'd3, 32'h33, 3);
    find();
    writeback(1'b1, 1'b1, 32'h34);
    push_find(3'd0, 32'h12, 5);
    find();
    writeback(1'b1, 1'b0, 32'h12);
    push_find(3'd0, 32'h12, 8);
    find();
    writeback(1'b0, 1'b1, 32'hDEAD);
    check_eq("wb_invalid_mem", dut.mem[0], 32'h12);
    push_find(3'd0, 32'h12, 8);
    find();

    writeback(1'b1, 1'b1, 32'h13);
    check_eq("finish_not_yet", {31'd0, is_finish}, 32'd0);
    state = 3'd7;
    step();
    check_eq("finish_rise", {31'd0, is_finish}, 32'd1);
    load_en = 1'b1; load_addr = 3'd0; load_data = 32'hFFFF;
    step();
    load_en = 1'b0;
    check_eq("done_mem", dut.mem[0], 32'h13);
    check_eq("done_pending", {24'd0, dut.pending}, 32'd0);
    check_eq("finish_sticky", {31'd0, is_finish}, 32'd1);

    // Reset in the middle of an iteration
    load(3'd0, 32'h11);
    load(3'd3, 32'h33);
    start_pulse();
    push_find(3'd3, 32'h33, 3);
    find();
    state = 3'd3;
    check_eq("pre_rst_pending", {24'd0, dut.pending}, 32'h09);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_pending", {24'd0, dut.pending}, 32'd0);
    check_eq("mid_rst_is_find", {31'd0, is_find}, 32'd0);
    check_eq("mid_rst_is_finish", {31'd0, is_finish}, 32'd0);
    step();
    rst = 1'b0;
    state = 3'd0;
    step();

    load(3'd5, 32'h55);
    start_pulse();
    push_find(3'd5, 32'h55, 6);
    find();
    writeback(1'b1, 1'b1, 32'h56);
    state = 3'd7;
    step();
    check_eq("fresh_finish", {31'd0, is_finish}, 32'd1);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
